// File: rtl/ff_wnd_pipe.sv
// Pipelined circular find-first-set: returns the first set bit at or after
// in_start, wrapping to the lowest set bit when none lies at or above it.
module ff_wnd_pipe #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned BLOCK_WIDTH = 4,
  localparam int unsigned IND_WIDTH  = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_val,
  output logic                 in_rdy,
  input  logic [WIDTH-1:0]     in_bitmap,
  input  logic [IND_WIDTH-1:0] in_start,
  output logic                 out_val,
  input  logic                 out_rdy,
  output logic                 out_found,
  output logic [IND_WIDTH-1:0] out_ind
);

  localparam int unsigned BB     = $clog2(BLOCK_WIDTH);
  localparam int unsigned LEVELS = (IND_WIDTH + BB - 1) / BB;
  localparam int unsigned PW     = LEVELS * BB;

  // Offset of tree level g's nodes within the flat registered node vectors.
  function automatic int unsigned off(input int unsigned g);
    int unsigned s;
    s = 0;
    for (int unsigned l = 1; l < g; l++) s += 1 << (BB * (LEVELS - l));
    return s;
  endfunction

  localparam int unsigned T  = off(LEVELS);
  localparam int unsigned TS = (T > 0) ? T : 1;

  // Least-significant valid child wins; an empty node yields {0, 0}.
  function automatic logic [PW:0] pick(input logic [BLOCK_WIDTH-1:0]    v,
                                       input logic [BLOCK_WIDTH*PW-1:0] i);
    logic [PW:0] r;
    r = '0;
    for (int unsigned k = BLOCK_WIDTH; k > 0; k--)
      if (v[k-1]) r = {1'b1, i[(k-1)*PW +: PW]};
    return r;
  endfunction

  logic              en;
  logic [LEVELS-1:0] vld_q;
  logic [WIDTH-1:0]  bm_hi_q, bm_full_q;
  logic [TS-1:0]     nv_h_q, nv_f_q, nv_h_d, nv_f_d;
  logic [TS*PW-1:0]  ni_h_q, ni_f_q, ni_h_d, ni_f_d;
  logic [PW:0]       fin_h, fin_f;

  assign en     = ~(out_val & ~out_rdy);
  assign in_rdy = en;

  for (genvar g = 1; g <= LEVELS; g++) begin : lvl
    localparam int unsigned NN = 1 << (BB * (LEVELS - g));
    localparam int unsigned NC = NN * BLOCK_WIDTH;
    logic [NC-1:0]    cv_h, cv_f;
    logic [NC*PW-1:0] ci_h, ci_f;

    if (g == 1) begin : leaf
      for (genvar c = 0; c < NC; c++) begin : lf
        if (c < WIDTH) begin : bit_in
          assign cv_h[c] = bm_hi_q[c];
          assign cv_f[c] = bm_full_q[c];
        end else begin : bit_pad
          assign cv_h[c] = 1'b0;
          assign cv_f[c] = 1'b0;
        end
        assign ci_h[c*PW +: PW] = PW'(c);
        assign ci_f[c*PW +: PW] = PW'(c);
      end
    end else begin : inner
      assign cv_h = nv_h_q[off(g-1) +: NC];
      assign cv_f = nv_f_q[off(g-1) +: NC];
      assign ci_h = ni_h_q[off(g-1)*PW +: NC*PW];
      assign ci_f = ni_f_q[off(g-1)*PW +: NC*PW];
    end

    if (g < LEVELS) begin : mid
      for (genvar n = 0; n < NN; n++) begin : nd
        assign {nv_h_d[off(g)+n], ni_h_d[(off(g)+n)*PW +: PW]} =
          pick(cv_h[n*BLOCK_WIDTH +: BLOCK_WIDTH], ci_h[n*BLOCK_WIDTH*PW +: BLOCK_WIDTH*PW]);
        assign {nv_f_d[off(g)+n], ni_f_d[(off(g)+n)*PW +: PW]} =
          pick(cv_f[n*BLOCK_WIDTH +: BLOCK_WIDTH], ci_f[n*BLOCK_WIDTH*PW +: BLOCK_WIDTH*PW]);
      end
    end else begin : last
      assign fin_h = pick(cv_h, ci_h);
      assign fin_f = pick(cv_f, ci_f);
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      bm_hi_q   <= in_bitmap & (~WIDTH'(0) << in_start);
      bm_full_q <= in_bitmap;
      nv_h_q    <= nv_h_d;
      nv_f_q    <= nv_f_d;
      ni_h_q    <= ni_h_d;
      ni_f_q    <= ni_f_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q     <= '0;
      out_val   <= 1'b0;
      out_found <= 1'b0;
      out_ind   <= '0;
    end else if (en) begin
      for (int unsigned k = LEVELS - 1; k > 0; k--) vld_q[k] <= vld_q[k-1];
      vld_q[0] <= in_val;
      out_val  <= vld_q[LEVELS-1];
      if (vld_q[LEVELS-1]) begin
        out_found <= fin_f[PW];
        out_ind   <= fin_h[PW] ? fin_h[IND_WIDTH-1:0] : fin_f[IND_WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_ff_wnd_pipe.sv
// Testbench for ff_wnd_pipe (WIDTH=16, BLOCK_WIDTH=4): directed cases, stall,
// mid-flight reset and a randomized scoreboard run against a circular-scan model.
module tb_ff_wnd_pipe;
  localparam int W  = 16;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst, in_val, in_rdy, out_val, out_rdy, out_found;
  logic [W-1:0]  in_bitmap;
  logic [IW-1:0] in_start, out_ind;

  int errors = 0;
  int checks = 0;
  int n_acc  = 0;
  logic [IW:0] exp_q[$];
  logic [IW:0] got_q[$];

  always #5 clk = ~clk;

  ff_wnd_pipe #(.WIDTH(W), .BLOCK_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .in_val(in_val), .in_rdy(in_rdy),
    .in_bitmap(in_bitmap), .in_start(in_start), .out_val(out_val),
    .out_rdy(out_rdy), .out_found(out_found), .out_ind(out_ind)
  );

  // Reference: scan indices start, start+1, ... modulo W; first set bit wins.
  function automatic logic [IW:0] ref_ff(input logic [W-1:0] bm, input logic [IW-1:0] st);
    logic [IW:0]   r;
    logic [IW-1:0] k;
    r = '0;
    for (int i = W - 1; i >= 0; i--) begin
      k = st + IW'(i);
      if (bm[k]) r = {1'b1, k};
    end
    return r;
  endfunction

  // One clock: record handshakes at the negedge, return just after the posedge.
  task automatic step();
    @(negedge clk);
    if (!rst && in_val && in_rdy) begin
      exp_q.push_back(ref_ff(in_bitmap, in_start));
      n_acc++;
    end
    if (!rst && out_val && out_rdy) got_q.push_back({out_found, out_ind});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL reset_out_val got=%b expected=0", out_val); end
    checks++; if (out_found !== 1'b0) begin errors++; $display("FAIL reset_out_found got=%b expected=0", out_found); end
    checks++; if (out_ind !== '0) begin errors++; $display("FAIL reset_out_ind got=%0d expected=0", out_ind); end
    repeat (2) step();
    rst = 1'b0;
    #1;
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL reset_in_rdy got=%b expected=1", in_rdy); end
  endtask

  task automatic test_directed();
    logic [W-1:0]  bms[6] = '{16'h0000, 16'h0120, 16'h0120, 16'h0021, 16'h8000, 16'h8000};
    logic [IW-1:0] sts[6] = '{4'd5, 4'd6, 4'd5, 4'd6, 4'd0, 4'd15};
    logic          efd[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [IW-1:0] ein[6] = '{4'd0, 4'd8, 4'd5, 4'd0, 4'd15, 4'd15};
    out_rdy = 1'b1;
    for (int v = 0; v < 6; v++) begin
      in_bitmap = bms[v]; in_start = sts[v]; in_val = 1'b1;
      step();
      in_val = 1'b0;
      for (int k = 0; k < 3; k++) begin
        if (k > 0) step();
        checks++;
        if (out_val !== 1'(k == 2)) begin
          errors++; $display("FAIL dir%0d_latency cyc=%0d got=%b expected=%b", v, k, out_val, k == 2);
        end
      end
      checks++;
      if (out_found !== efd[v] || out_ind !== ein[v]) begin
        errors++;
        $display("FAIL dir%0d_result got=%b/%0d expected=%b/%0d", v, out_found, out_ind, efd[v], ein[v]);
      end
      step();
      checks++;
      if (out_val !== 1'b0 || got_q.size() != 1) begin
        errors++; $display("FAIL dir%0d_single got out_val=%b n=%0d expected 0/1", v, out_val, got_q.size());
      end
      exp_q.delete(); got_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0]  bm[4] = '{16'h0120, 16'h0021, 16'h8000, 16'h00F0};
    logic [IW-1:0] st[4] = '{4'd6, 4'd6, 4'd0, 4'd9};
    logic [IW:0]   g, e;
    exp_q.delete(); got_q.delete();
    out_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_bitmap = bm[i]; in_start = st[i]; in_val = 1'b1;
      step();
    end
    out_rdy = 1'b0;
    in_bitmap = bm[3]; in_start = st[3];
    #1;
    for (int s = 0; s < 3; s++) begin
      checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL stall%0d_in_rdy got=%b expected=0", s, in_rdy); end
      checks++; if (out_val !== 1'b1) begin errors++; $display("FAIL stall%0d_out_val got=%b expected=1", s, out_val); end
      checks++;
      if ({out_found, out_ind} !== 5'h18) begin
        errors++; $display("FAIL stall%0d_frozen got=%h expected=18", s, {out_found, out_ind});
      end
      step();
    end
    out_rdy = 1'b1;
    step();
    in_val = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++; if (out_val !== 1'b1) begin errors++; $display("FAIL b2b_stream%0d got=%b expected=1", k, out_val); end
      step();
    end
    checks++;
    if (got_q.size() != 4 || exp_q.size() != 4) begin
      errors++; $display("FAIL b2b_count got=%0d expected=4 (accepted %0d)", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL b2b_order got=%h expected=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_mid();
    exp_q.delete(); got_q.delete();
    out_rdy = 1'b1;
    in_bitmap = 16'h0120; in_start = 4'd6; in_val = 1'b1;
    step();
    in_bitmap = 16'h8000; in_start = 4'd0;
    step();
    in_val = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL midrst_async got=%b expected=0", out_val); end
    step();
    rst = 1'b0;
    exp_q.delete(); got_q.delete();
    #1;
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL midrst_in_rdy got=%b expected=1", in_rdy); end
    for (int k = 0; k < 6; k++) begin
      step();
      checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL midrst_ghost%0d got=%b expected=0", k, out_val); end
    end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL midrst_results got=%0d expected=0", got_q.size()); end
  endtask

  task automatic test_random();
    int          cyc = 0;
    logic [IW:0] g, e;
    exp_q.delete(); got_q.delete();
    n_acc = 0;
    while (n_acc < 10000 && cyc < 60000) begin
      in_val = ($urandom_range(3) != 0);
      case ($urandom_range(3))
        0:       in_bitmap = '0;
        1:       in_bitmap = W'(1) << $urandom_range(W - 1);
        2:       in_bitmap = W'($urandom & $urandom & $urandom);
        default: in_bitmap = W'($urandom);
      endcase
      in_start = IW'($urandom);
      out_rdy  = ($urandom_range(9) < 7);
      step();
      cyc++;
      while (got_q.size() > 0) begin
        g = got_q.pop_front();
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_extra got=%h expected=none", g);
        end else begin
          e = exp_q.pop_front();
          if (g !== e) begin errors++; $display("FAIL rand_cmp got=%h expected=%h", g, e); end
        end
      end
    end
    in_val = 1'b0; out_rdy = 1'b1;
    repeat (6) step();
    while (got_q.size() > 0) begin
      g = got_q.pop_front();
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL rand_extra got=%h expected=none", g);
      end else begin
        e = exp_q.pop_front();
        if (g !== e) begin errors++; $display("FAIL rand_cmp got=%h expected=%h", g, e); end
      end
    end
    checks++; if (n_acc < 10000) begin errors++; $display("FAIL rand_budget got=%0d expected=10000", n_acc); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_lost got=%0d expected=0", exp_q.size()); end
  endtask

  initial begin
    rst = 1'b0; in_val = 1'b0; out_rdy = 1'b1; in_bitmap = '0; in_start = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule

// File: doc/ff_wnd_pipe.md
FF_WND_PIPE -- requirements
Module: ff_wnd_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16: bitmap width in bits; power of 2, at least BLOCK_WIDTH.
REQ-002 SHALL have parameter BLOCK_WIDTH, default 4: fan-in of each find-first tree node; power of 2, at least 2.
REQ-003 SHALL derive localparams:
  - IND_WIDTH = clogb2(WIDTH).
  - LEVELS = ceil(IND_WIDTH / clogb2(BLOCK_WIDTH)).
REQ-004 SHALL have clk, input, 1: sole clock; all state on rising edge.
REQ-005 SHALL have rst, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have in_val, input, 1: request valid.
REQ-007 SHALL have in_rdy, output, 1: request accepted this cycle when in_val & in_rdy.
REQ-008 SHALL have in_bitmap, input, WIDTH: bits to search; bit i means index i is set.
REQ-009 SHALL have in_start, input, IND_WIDTH: circular search start index.
REQ-010 SHALL have out_val, output, 1: result valid.
REQ-011 SHALL have out_rdy, input, 1: result consumed when out_val & out_rdy.
REQ-012 SHALL have out_found, output, 1: at least one bit set in the request's bitmap.
REQ-013 SHALL have out_ind, output, IND_WIDTH: index of the first set bit found by the circular search.

Function
REQ-014 SHALL return the lowest set index i >= in_start; if none exists, the lowest set index i < in_start (circular wrap).
REQ-015 SHALL drive out_found=0 and out_ind=0 when in_bitmap is all zeros.
REQ-016 SHALL build two parallel trees per request:
  - hi tree: bitmap masked to bits >= start.
  - full tree: unmasked bitmap.
  - Each tree node returns the least-significant valid {val, ind} among BLOCK_WIDTH children.
REQ-017 SHALL register the masked and unmasked bitmaps in stage 0 at acceptance.
REQ-018 SHALL register exactly one tree level per pipeline stage.
REQ-019 SHALL compute the final hi/full select in the last level's stage (hi result if hi found, else full result); out_* SHALL come directly from flops.
REQ-020 SHALL make latency exactly LEVELS+1 cycles: request accepted at edge E0 gives out_val high after edge E0+LEVELS, absent backpressure.
REQ-021 SHALL carry a valid bit alongside every stage; bubbles SHALL propagate as invalid stages.
REQ-022 SHALL use one global pipeline enable: en = ~(out_val & ~out_rdy).
REQ-023 SHALL drive in_rdy = en (combinational).
REQ-024 SHALL hold all stage registers, including out_*, unchanged while en=0.
REQ-025 SHALL accept one request per cycle while out_rdy is held high (full throughput).
REQ-026 SHALL deliver results in acceptance order, with no loss or duplication under any out_rdy pattern.
REQ-027 SHALL hold out_found and out_ind stable while out_val & ~out_rdy.
REQ-028 SHALL treat in_bitmap/in_start as don't-care when in_val=0; the stage valid bit is cleared.
REQ-029 SHALL pad node inputs beyond WIDTH with val=0 when IND_WIDTH is not a multiple of clogb2(BLOCK_WIDTH).
REQ-030 SHALL search the whole bitmap directly when in_start=0; the wrap path SHALL never be needed.
REQ-031 SHALL return in_start itself when bit in_start is set (inclusive start).

Reset
REQ-032 SHALL, while rst=1, asynchronously clear every stage valid bit, out_val, out_found and out_ind to 0.
REQ-033 SHALL make in_rdy=1 immediately after reset deassertion.
REQ-034 SHALL discard all in-flight requests when rst asserts mid-operation; no result from them SHALL appear after reset.
REQ-035 SHALL allow datapath flops other than valid/out bits to be non-reset.

Verification (WIDTH=16, BLOCK_WIDTH=4, LEVELS=2, out_rdy=1 unless stated)
REQ-036 SHALL cover: bitmap 0x0000, start 5 -> out_found=0, out_ind=0, out_val high 3 cycles after acceptance (edge E0+2).
REQ-037 SHALL cover: bitmap 0x0120, start 6 -> out_ind=8; same bitmap, start 5 -> out_ind=5 (inclusive).
REQ-038 SHALL cover: bitmap 0x0021, start 6 -> out_ind=0 (wrap); bitmap 0x8000, start 0 -> 15; bitmap 0x8000, start 15 -> 15.
REQ-039 SHALL cover: four back-to-back requests, out_rdy low for 3 cycles while the first result is valid.
  - in_rdy low during the stall.
  - out_* frozen during the stall.
  - All four results emerge in order, one per cycle, after out_rdy rises.
REQ-040 SHALL cover: rst pulsed one cycle after two requests are accepted -> out_val stays 0 thereafter until a new request is accepted.
REQ-041 SHALL cover: randomized compare against a reference model for 10k requests with random out_rdy -> zero mismatches.
